grn_node_multi: RTL and testbench
=================================

# grn_node_multi

Parametrised gene-regulatory-network node for the Boolean-network simulation fabric. It holds NCOPIES independent state copies of one gene and updates each copy from its own slice of regulator inputs. The update is an activator-OR / inhibitor-veto function fixed by parameter masks. Each copy has a per-copy update divider, and an optional stability detector flags copies whose state has stopped changing. It drops into the same node array as the existing two-copy nodes, driven by the same global `reset_nos`/start controller.

## Interface
- `NCOPIES`, 2: number of independent state copies (simulation lanes), ≥1.
- `NINPUTS`, 3: regulator inputs per copy, ≥1.
- `ACT_MASK`, {NINPUTS{1'b1}}: bit i=1 → input i is an activator.
- `INH_MASK`, 0: bit i=1 → input i is an inhibitor. ACT_MASK & INH_MASK must be 0; an overlap is flagged by an elaboration-time check.
- `DELAY`, 0: start pulses skipped between updates, 0..15 (0 = update on every start).
- `STABLE_TH`, 4: consecutive unchanged updates needed to assert `stable`, 1..255.

Ports:
- `clk`  in  1  clock.
- `rst_n`  in  1  asynchronous, active-low reset.
- `reset_nos`  in  1  synchronous reload of all copies from `init_state`.
- `init_state`  in  1  state loaded by `reset_nos`.
- `start`  in  NCOPIES  per-copy update strobe, bit c drives copy c.
- `in_bus`  in  NCOPIES*NINPUTS  regulator inputs; copy c input i is bit c*NINPUTS+i.
- `s`  out  NCOPIES  node state per copy.
- `changed`  out  NCOPIES  copy's last update changed `s`.
- `stable`  out  NCOPIES  copy has had ≥STABLE_TH consecutive unchanged updates.

## Operation
- Next-state function per copy:
  - act = |(in_c & ACT_MASK), forced to 1 when ACT_MASK==0.
  - inh = |(in_c & INH_MASK).
  - f = act & ~inh.
- Per-copy divider `dcnt[c]`, width clog2(DELAY+1) (min 1).
- Priority per copy: `rst_n` low > `reset_nos` > `start[c]` > hold.
- On `reset_nos`:
  - `s[c]`←init_state, `dcnt[c]`←DELAY, `changed[c]`←0.
  - Stability counter `scnt[c]`←0, `stable[c]`←0.
- On `start[c]` with `dcnt[c]==DELAY`, this is an update:
  - `s[c]`←f, `dcnt[c]`←0.
  - `changed[c]`←(f != s[c]).
  - Stability: if f != s[c], `scnt[c]`←0; else `scnt[c]`←min(scnt+1, STABLE_TH).
  - `stable[c]`←(next scnt == STABLE_TH).
- On `start[c]` with `dcnt[c]<DELAY`, this is a skip: `dcnt[c]`++ and everything else holds.
- The first start after `reset_nos` always updates, because dcnt was loaded with DELAY.
- Copies are fully independent. Simultaneous starts on any subset are legal.
- `scnt` width is clog2(STABLE_TH+1). It saturates at STABLE_TH and never wraps.

## Timing
- Reset (`rst_n` low, asynchronous): `s`=0, `changed`=0, `stable`=0, `dcnt`=0, `scnt`=0.
  - After reset deassertion, copy c performs its first update only after DELAY skipped starts, unless `reset_nos` is issued first.
- Update latency: `s`, `changed` and `stable` reflect an update on the clock edge that samples `start[c]`=1. `in_bus` is sampled on that same edge.
- `reset_nos` has a 1-cycle effect and overrides a coincident `start`.
- `rst_n` asserted mid-operation clears all state immediately, regardless of clk.
- `stable` deasserts on the same edge as the first changing update.
- `changed` holds its value across skips and idle cycles until the next update.

## Configuration
- `GRN_NODE_STABLE_EN` defined: `scnt`, `changed` and `stable` logic as described.
- `GRN_NODE_STABLE_EN` undefined:
  - No `scnt` registers.
  - `changed` and `stable` are tied to 0.
  - State and divider behaviour is identical to the defined case.

## Test plan
- **Basic OR update.** Defaults (NCOPIES=2, NINPUTS=3, DELAY=0), `reset_nos` with init_state=0, then start=2'b11 with in_bus=6'b000_010.
  - Next edge: s=2'b01, changed=2'b01.
- **Inhibitor veto.** ACT_MASK=3'b011, INH_MASK=3'b100, copy0 inputs 3'b101, start[0].
  - s[0]=0.
  - Inputs 3'b001 on the next start → s[0]=1.
- **Divider.** DELAY=2, `reset_nos`, constant f=1, start[0] pulsed 7 times.
  - Updates on pulses 1, 4, 7 only.
  - dcnt sequence after each pulse: 0, 1, 2, 0, 1, 2, 0.
- **Stability.** STABLE_TH=3, constant inputs, start each cycle.
  - stable[0] rises on the 4th update (1st update changes 0→1; then 3 unchanged updates).
  - Toggling one input on the next start → stable=0, changed=1 on that edge.
- **Priority and async reset.** `reset_nos` and start together → s=init_state.
  - Pulse `rst_n` low for a half-cycle between edges → s, changed, stable are 0 immediately, before the next clk edge.
- **Macro off.** Build without `GRN_NODE_STABLE_EN` and rerun the stability scenario.
  - s sequence is identical.
  - changed and stable stay 0 throughout.

Source files
------------

// File: rtl/grn_node_multi.sv
// Multi-copy Boolean gene-regulatory-network node: activator-OR / inhibitor-veto update with per-copy start divider.
// Define GRN_NODE_STABLE_EN to build the per-copy changed/stable tracking; otherwise both outputs are tied low.
module grn_node_multi #(
    parameter int NCOPIES = 2,
    parameter int NINPUTS = 3,
    parameter logic [NINPUTS-1:0] ACT_MASK = {NINPUTS{1'b1}},
    parameter logic [NINPUTS-1:0] INH_MASK = {NINPUTS{1'b0}},
    parameter int DELAY = 0,
    parameter int STABLE_TH = 4
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         reset_nos,
    input  logic                         init_state,
    input  logic [NCOPIES-1:0]           start,
    input  logic [NCOPIES*NINPUTS-1:0]   in_bus,
    output logic [NCOPIES-1:0]           s,
    output logic [NCOPIES-1:0]           changed,
    output logic [NCOPIES-1:0]           stable
);

    localparam int DW = (DELAY > 0) ? $clog2(DELAY + 1) : 1;
    localparam logic [DW-1:0] DMAX = DW'(DELAY);

    generate
        if ((ACT_MASK & INH_MASK) != {NINPUTS{1'b0}}) begin : g_mask_overlap
            $error("grn_node_multi: ACT_MASK and INH_MASK overlap");
        end
    endgenerate

    logic [NCOPIES-1:0]          f_s;
    logic [NCOPIES-1:0]          s_r;
    logic [NCOPIES-1:0]          s_nxt;
    logic [NCOPIES-1:0][DW-1:0]  dcnt_r;
    logic [NCOPIES-1:0][DW-1:0]  dcnt_nxt;

    // Regulatory function per copy; an empty activator mask means "always active".
    always_comb begin
        f_s = {NCOPIES{1'b0}};
        for (int c = 0; c < NCOPIES; c++) begin
            f_s[c] = ((ACT_MASK == {NINPUTS{1'b0}}) | (|(in_bus[c*NINPUTS +: NINPUTS] & ACT_MASK)))
                     & ~(|(in_bus[c*NINPUTS +: NINPUTS] & INH_MASK));
        end
    end

    // Next state and divider: reload beats start, a start updates only once the divider is full.
    always_comb begin
        s_nxt    = s_r;
        dcnt_nxt = dcnt_r;
        for (int c = 0; c < NCOPIES; c++) begin
            if (reset_nos) begin
                s_nxt[c]    = init_state;
                dcnt_nxt[c] = DMAX;
            end else if (start[c]) begin
                if (dcnt_r[c] == DMAX) begin
                    s_nxt[c]    = f_s[c];
                    dcnt_nxt[c] = {DW{1'b0}};
                end else begin
                    dcnt_nxt[c] = dcnt_r[c] + DW'(1);
                end
            end else begin
                s_nxt[c]    = s_r[c];
                dcnt_nxt[c] = dcnt_r[c];
            end
        end
    end

    // State and divider registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s_r    <= {NCOPIES{1'b0}};
            dcnt_r <= {(NCOPIES*DW){1'b0}};
        end else begin
            s_r    <= s_nxt;
            dcnt_r <= dcnt_nxt;
        end
    end

    assign s = s_r;

`ifdef GRN_NODE_STABLE_EN
    localparam int SW = $clog2(STABLE_TH + 1);
    localparam logic [SW-1:0] STH = SW'(STABLE_TH);

    logic [NCOPIES-1:0]          changed_r;
    logic [NCOPIES-1:0]          changed_nxt;
    logic [NCOPIES-1:0]          stable_r;
    logic [NCOPIES-1:0]          stable_nxt;
    logic [NCOPIES-1:0][SW-1:0]  scnt_r;
    logic [NCOPIES-1:0][SW-1:0]  scnt_nxt;

    // Run length of unchanged updates, saturating at the threshold; skips and idle cycles hold.
    always_comb begin
        changed_nxt = changed_r;
        stable_nxt  = stable_r;
        scnt_nxt    = scnt_r;
        for (int c = 0; c < NCOPIES; c++) begin
            if (reset_nos) begin
                changed_nxt[c] = 1'b0;
                stable_nxt[c]  = 1'b0;
                scnt_nxt[c]    = {SW{1'b0}};
            end else if (start[c] && (dcnt_r[c] == DMAX)) begin
                if (f_s[c] != s_r[c]) begin
                    changed_nxt[c] = 1'b1;
                    scnt_nxt[c]    = {SW{1'b0}};
                end else begin
                    changed_nxt[c] = 1'b0;
                    scnt_nxt[c]    = (scnt_r[c] == STH) ? STH : (scnt_r[c] + SW'(1));
                end
                stable_nxt[c] = (scnt_nxt[c] == STH);
            end else begin
                changed_nxt[c] = changed_r[c];
                stable_nxt[c]  = stable_r[c];
                scnt_nxt[c]    = scnt_r[c];
            end
        end
    end

    // Stability tracking registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            changed_r <= {NCOPIES{1'b0}};
            stable_r  <= {NCOPIES{1'b0}};
            scnt_r    <= {(NCOPIES*SW){1'b0}};
        end else begin
            changed_r <= changed_nxt;
            stable_r  <= stable_nxt;
            scnt_r    <= scnt_nxt;
        end
    end

    assign changed = changed_r;
    assign stable  = stable_r;
`else
    assign changed = {NCOPIES{1'b0}};
    assign stable  = {NCOPIES{1'b0}};
`endif

endmodule

// File: tb/tb_grn_node_multi.sv
// Bench for grn_node_multi: vector table, hand sequences and random stimulus against a behavioural model.
module tb_grn_node_multi;

`ifdef GRN_NODE_STABLE_EN
    localparam bit STAB_EN = 1'b1;
`else
    localparam bit STAB_EN = 1'b0;
`endif

    localparam int       P_NC  [3] = '{2, 2, 3};
    localparam logic [2:0] P_ACT [3] = '{3'b111, 3'b011, 3'b111};
    localparam logic [2:0] P_INH [3] = '{3'b000, 3'b100, 3'b000};
    localparam int       P_DEL [3] = '{0, 0, 2};
    localparam int       P_TH  [3] = '{3, 4, 2};

    logic        clk;
    logic        rst_n;
    logic [2:0]  rn;
    logic [2:0]  ini;
    logic [3:0]  stv [3];
    logic [11:0] inv [3];

    logic [1:0] s_a, ch_a, st_a, s_b, ch_b, st_b;
    logic [2:0] s_c, ch_c, st_c;
    logic [3:0] o_s [3];
    logic [3:0] o_ch [3];
    logic [3:0] o_st [3];

    int tests;
    int fails;

    int m_s   [3][4];
    int m_sk  [3][4];
    int m_ch  [3][4];
    int m_run [3][4];

    grn_node_multi #(.NCOPIES(2), .NINPUTS(3), .DELAY(0), .STABLE_TH(3)) dut_a (
        .clk(clk), .rst_n(rst_n), .reset_nos(rn[0]), .init_state(ini[0]),
        .start(stv[0][1:0]), .in_bus(inv[0][5:0]), .s(s_a), .changed(ch_a), .stable(st_a));

    grn_node_multi #(.NCOPIES(2), .NINPUTS(3), .ACT_MASK(3'b011), .INH_MASK(3'b100),
                     .DELAY(0), .STABLE_TH(4)) dut_b (
        .clk(clk), .rst_n(rst_n), .reset_nos(rn[1]), .init_state(ini[1]),
        .start(stv[1][1:0]), .in_bus(inv[1][5:0]), .s(s_b), .changed(ch_b), .stable(st_b));

    grn_node_multi #(.NCOPIES(3), .NINPUTS(3), .DELAY(2), .STABLE_TH(2)) dut_c (
        .clk(clk), .rst_n(rst_n), .reset_nos(rn[2]), .init_state(ini[2]),
        .start(stv[2][2:0]), .in_bus(inv[2][8:0]), .s(s_c), .changed(ch_c), .stable(st_c));

    assign o_s[0]  = {2'b00, s_a};
    assign o_ch[0] = {2'b00, ch_a};
    assign o_st[0] = {2'b00, st_a};
    assign o_s[1]  = {2'b00, s_b};
    assign o_ch[1] = {2'b00, ch_b};
    assign o_st[1] = {2'b00, st_b};
    assign o_s[2]  = {1'b0, s_c};
    assign o_ch[2] = {1'b0, ch_c};
    assign o_st[2] = {1'b0, st_c};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic       rn;
        logic       ini;
        logic [1:0] st;
        logic [5:0] in;
        logic [1:0] es;
        logic [1:0] ec;
        logic [1:0] et;
    } vec_t;

    vec_t tbl [9];

    task automatic check(input string nm, input logic [3:0] act, input logic [3:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s got=%b want=%b at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int k = 0; k < 3; k++) begin
            for (int c = 0; c < 4; c++) begin
                m_s[k][c] = 0; m_sk[k][c] = 0; m_ch[k][c] = 0; m_run[k][c] = 0;
            end
        end
    endtask

    // Behaviour straight from the rules: an update happens once DELAY starts have been skipped.
    task automatic model_step();
        logic [2:0] a;
        int f;
        for (int k = 0; k < 3; k++) begin
            for (int c = 0; c < P_NC[k]; c++) begin
                if (!rst_n) begin
                    m_s[k][c] = 0; m_sk[k][c] = 0; m_ch[k][c] = 0; m_run[k][c] = 0;
                end else if (rn[k]) begin
                    m_s[k][c] = int'(ini[k]); m_sk[k][c] = P_DEL[k]; m_ch[k][c] = 0; m_run[k][c] = 0;
                end else if (stv[k][c]) begin
                    if (m_sk[k][c] == P_DEL[k]) begin
                        a = inv[k][c*3 +: 3];
                        f = ((P_ACT[k] == 3'b000 || (a & P_ACT[k]) != 3'b000) && (a & P_INH[k]) == 3'b000) ? 1 : 0;
                        m_ch[k][c]  = (f != m_s[k][c]) ? 1 : 0;
                        m_run[k][c] = (m_ch[k][c] != 0) ? 0 : m_run[k][c] + 1;
                        m_s[k][c]   = f;
                        m_sk[k][c]  = 0;
                    end else begin
                        m_sk[k][c] = m_sk[k][c] + 1;
                    end
                end
            end
        end
    endtask

    task automatic check_inst(input int k, input string nm);
        logic [3:0] es, ec, et;
        es = 4'b0000; ec = 4'b0000; et = 4'b0000;
        for (int c = 0; c < P_NC[k]; c++) begin
            es[c] = (m_s[k][c] != 0);
            ec[c] = STAB_EN && (m_ch[k][c] != 0);
            et[c] = STAB_EN && (m_run[k][c] >= P_TH[k]);
        end
        check({nm, "_s"}, o_s[k], es);
        check({nm, "_changed"}, o_ch[k], ec);
        check({nm, "_stable"}, o_st[k], et);
    endtask

    task automatic tick();
        @(posedge clk);
        model_step();
        #1;
    endtask

    task automatic idle_inputs();
        for (int k = 0; k < 3; k++) begin
            rn[k] = 1'b0; ini[k] = 1'b0; stv[k] = 4'b0000; inv[k] = 12'h000;
        end
    endtask

    logic [6:0] div_exp;

    initial begin
        tests = 0;
        fails = 0;
        rst_n = 1'b0;
        idle_inputs();
        model_reset();
        #3;
        for (int k = 0; k < 3; k++) begin
            check("reset_s", o_s[k], 4'b0000);
            check("reset_changed", o_ch[k], 4'b0000);
            check("reset_stable", o_st[k], 4'b0000);
        end
        #9 rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Basic OR update, stability ramp, toggle, reload priority, changed hold.
        tbl[0] = '{rn:1'b1, ini:1'b0, st:2'b00, in:6'b000_000, es:2'b00, ec:2'b00, et:2'b00};
        tbl[1] = '{rn:1'b0, ini:1'b0, st:2'b11, in:6'b000_010, es:2'b01, ec:2'b01, et:2'b00};
        tbl[2] = '{rn:1'b0, ini:1'b0, st:2'b11, in:6'b000_010, es:2'b01, ec:2'b00, et:2'b00};
        tbl[3] = '{rn:1'b0, ini:1'b0, st:2'b11, in:6'b000_010, es:2'b01, ec:2'b00, et:2'b10};
        tbl[4] = '{rn:1'b0, ini:1'b0, st:2'b11, in:6'b000_010, es:2'b01, ec:2'b00, et:2'b11};
        tbl[5] = '{rn:1'b0, ini:1'b0, st:2'b11, in:6'b000_000, es:2'b00, ec:2'b01, et:2'b10};
        tbl[6] = '{rn:1'b1, ini:1'b1, st:2'b11, in:6'b000_000, es:2'b11, ec:2'b00, et:2'b00};
        tbl[7] = '{rn:1'b0, ini:1'b0, st:2'b01, in:6'b000_000, es:2'b10, ec:2'b01, et:2'b00};
        tbl[8] = '{rn:1'b0, ini:1'b0, st:2'b00, in:6'b000_000, es:2'b10, ec:2'b01, et:2'b00};
        for (int i = 0; i < 9; i++) begin
            rn[0] = tbl[i].rn; ini[0] = tbl[i].ini;
            stv[0] = {2'b00, tbl[i].st}; inv[0] = {6'b000000, tbl[i].in};
            tick();
            check($sformatf("tbl%0d_s", i), o_s[0], {2'b00, tbl[i].es});
            check($sformatf("tbl%0d_changed", i), o_ch[0], {2'b00, STAB_EN ? tbl[i].ec : 2'b00});
            check($sformatf("tbl%0d_stable", i), o_st[0], {2'b00, STAB_EN ? tbl[i].et : 2'b00});
        end
        idle_inputs();

        // Inhibitor veto on dut_b.
        rn[1] = 1'b1; tick(); rn[1] = 1'b0;
        stv[1] = 4'b0001; inv[1] = 12'b000_101;
        tick();
        check("veto_s0", {3'b000, s_b[0]}, 4'b0000);
        inv[1] = 12'b000_001;
        tick();
        check("veto_release_s0", {3'b000, s_b[0]}, 4'b0001);
        check_inst(1, "veto_model");
        idle_inputs();

        // Divider on dut_c: f alternates per pulse, only pulses 1, 4 and 7 land.
        div_exp = 7'b1000111;
        rn[2] = 1'b1; tick(); rn[2] = 1'b0;
        for (int p = 1; p <= 7; p++) begin
            stv[2] = 4'b0001;
            inv[2] = (p % 2 == 1) ? 12'b000_000_001 : 12'b000_000_000;
            tick();
            check($sformatf("div_pulse%0d_s0", p), {3'b000, s_c[0]}, {3'b000, div_exp[p-1]});
        end
        idle_inputs();
        tick();

        // Asynchronous reset between edges.
        #2 rst_n = 1'b0;
        model_reset();
        #1;
        for (int k = 0; k < 3; k++) begin
            check("async_s", o_s[k], 4'b0000);
            check("async_changed", o_ch[k], 4'b0000);
            check("async_stable", o_st[k], 4'b0000);
        end
        #1 rst_n = 1'b1;

        // After a hard reset the divider starts empty: two skips before the first update.
        for (int p = 0; p < 3; p++) begin
            stv[2] = 4'b0001; inv[2] = 12'b000_000_001;
            tick();
            check($sformatf("post_rst_pulse%0d_s0", p), {3'b000, s_c[0]}, (p == 2) ? 4'b0001 : 4'b0000);
        end
        idle_inputs();

        // Random traffic on all three instances against the model.
        for (int i = 0; i < 400; i++) begin
            for (int k = 0; k < 3; k++) begin
                rn[k]  = ($urandom_range(0, 24) == 0);
                ini[k] = 1'($urandom_range(0, 1));
                stv[k] = 4'($urandom_range(0, 15));
                inv[k] = ($urandom_range(0, 3) == 0) ? 12'h000 : 12'($urandom);
            end
            tick();
            check_inst(0, "rnd_a");
            check_inst(1, "rnd_b");
            check_inst(2, "rnd_c");
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
